// File: rtl/uart_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_receiver - oversampled UART RX: start-glitch reject, mid-bit sample, |
// | stop check, one-entry valid/ready holding register.       Rev 1.0         |
// +--------------------------------------------------------------------------+
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 SamplingTick,
  input  logic                 RxSerial,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  input  logic                 RxReady,
  output logic                 FramingError,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_DATA  = 2'd2;
  localparam logic [1:0] c_ST_STOP  = 2'd3;

  // Counter resets to 0 on a transition and counts from the next tick, so the
  // start re-check lands on tick OVERSAMPLE/2-1 after the start-detect tick.
  localparam logic [TW-1:0] c_HALF = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] c_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] c_LAST = BW'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [TW-1:0]        r_tick;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 w_shift_en;
  logic                 w_stop_sample;
  logic                 w_frame_ok;
  logic                 w_frame_bad;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RxSerial;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) r_state <= c_ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (SamplingTick && !r_sync2) w_next = c_ST_START;
      c_ST_START: if (SamplingTick && r_tick == c_HALF)
                    w_next = r_sync2 ? c_ST_IDLE : c_ST_DATA;
      c_ST_DATA:  if (SamplingTick && r_tick == c_FULL && r_bit == c_LAST)
                    w_next = c_ST_STOP;
      c_ST_STOP:  if (SamplingTick && r_tick == c_FULL) w_next = c_ST_IDLE;
      default:    w_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_shift_en    = 1'b0;
    w_stop_sample = 1'b0;
    case (r_state)
      c_ST_DATA: w_shift_en    = SamplingTick && (r_tick == c_FULL);
      c_ST_STOP: w_stop_sample = SamplingTick && (r_tick == c_FULL);
      default:   ;
    endcase
  end

  assign w_frame_ok  = w_stop_sample &  r_sync2;
  assign w_frame_bad = w_stop_sample & ~r_sync2;
  assign Busy        = (r_state != c_ST_IDLE);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (w_next != r_state)  r_tick <= '0;
      else if (SamplingTick)  r_tick <= r_tick + 1'b1;

      if (r_state == c_ST_IDLE) begin
        r_bit <= '0;
      end else if (w_shift_en) begin
        r_bit   <= r_bit + 1'b1;
        r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  // A completed byte may replace a held one only when it is consumed that cycle.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_frame_bad;
      r_ovr  <= 1'b0;
      if (w_frame_ok) begin
        if (!r_valid || RxReady) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && RxReady) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign RxData       = r_data;
  assign RxValid      = r_valid;
  assign FramingError = r_ferr;
  assign Overrun      = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_receiver - scoreboarded random and directed bench for uart_rx.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_uart_receiver;

  localparam int DB      = 8;
  localparam int OS      = 16;
  localparam int BIT_CYC = 64;
  localparam int EV_LOAD = 0;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  logic       Clock = 1'b0;
  logic       ResetN = 1'b0;
  logic       SamplingTick = 1'b0;
  logic       RxSerial = 1'b1;
  logic       RxReady = 1'b0;
  logic [7:0] RxData;
  logic       RxValid;
  logic       FramingError;
  logic       Overrun;
  logic       Busy;

  uart_receiver #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .Clock        (Clock),
    .ResetN       (ResetN),
    .SamplingTick (SamplingTick),
    .RxSerial     (RxSerial),
    .RxData       (RxData),
    .RxValid      (RxValid),
    .RxReady      (RxReady),
    .FramingError (FramingError),
    .Overrun      (Overrun),
    .Busy         (Busy)
  );

  always #5 Clock = ~Clock;

  int tph = 0;
  initial forever begin
    @(negedge Clock);
    tph = (tph + 1) % 4;
    SamplingTick = (tph == 0);
  end

  int tickno = 0;
  always @(posedge Clock) if (SamplingTick) tickno <= tickno + 1;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  bit  m_valid  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every frame sent yields exactly one observable event, in order.
  function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit acc);
    ev_t e;
    e.data = 8'h00;
    if (!stop_ok) begin
      e.kind = EV_FERR;
    end else if (!m_valid || acc) begin
      e.kind = EV_LOAD;
      e.data = b;
      m_valid = 1'b1;
    end else begin
      e.kind = EV_OVR;
    end
    exp_q.push_back(e);
  endfunction

  task automatic got(input int kind, input logic [7:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_unexpected actual kind=%0d data=%02h required=no event", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== data) begin
        failures++;
        $display("FAIL scoreboard_event actual kind=%0d data=%02h required kind=%0d data=%02h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  logic mon_prev_valid = 1'b0;
  logic mon_prev_ready = 1'b0;
  always @(posedge Clock) mon_prev_ready = RxReady;

  always @(negedge Clock) begin
    if (!ResetN) begin
      mon_prev_valid = 1'b0;
    end else begin
      if (RxValid && (!mon_prev_valid || mon_prev_ready)) got(EV_LOAD, RxData);
      if (FramingError) got(EV_FERR, 8'h00);
      if (Overrun)      got(EV_OVR, 8'h00);
      mon_prev_valid = RxValid;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic align_tick();
    int n;
    n = 0;
    do begin
      @(posedge Clock);
      #1;
      n++;
    end while (!SamplingTick && n < 16);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit acc, input bit jit);
    int       bnd[11];
    logic [9:0] fr;
    int       t0;
    logic     lvl;
    model_frame(b, stop_ok, acc);
    align_tick();
    if (!acc) step($urandom_range(0, 3));
    t0 = tickno;
    fr = {stop_ok, b, 1'b0};
    bnd[0] = 0;
    for (int i = 1; i < 10; i++)
      bnd[i] = i * BIT_CYC + (jit ? int'($urandom_range(0, 12)) - 6 : 0);
    bnd[10] = stop_ok ? 10 * BIT_CYC : bnd[9] + 40;
    if (acc) begin
      fork
        begin
          int tgt;
          int n;
          tgt = t0 + 151;
          n = 0;
          do begin
            @(negedge Clock);
            #1;
            n++;
          end while (!(SamplingTick && tickno == tgt) && n < 2000);
          RxReady = 1'b1;
          @(posedge Clock);
          #1;
          RxReady = 1'b0;
        end
      join_none
    end
    for (int c = 0; c < 10 * BIT_CYC; c++) begin
      lvl = 1'b1;
      for (int i = 0; i < 10; i++)
        if (c >= bnd[i] && c < bnd[i+1]) lvl = fr[i];
      RxSerial = lvl;
      step(1);
    end
    RxSerial = 1'b1;
    if (!stop_ok) step(2 * BIT_CYC);
  endtask

  task automatic accept_byte();
    int n;
    n = 0;
    while (!RxValid && n < 400) begin
      step(1);
      n++;
    end
    chk("accept_wait_valid", RxValid, 1);
    RxReady = 1'b1;
    step(1);
    RxReady = 1'b0;
    m_valid = 1'b0;
    @(negedge Clock);
    chk("accept_clears_valid", RxValid, 0);
    step(1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step(1);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  function automatic logic [11:0] outs();
    return {RxData, RxValid, FramingError, Overrun, Busy};
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit saw;
    bit ok;
    logic [7:0] b;

    // Reset held with a toggling line
    for (int i = 0; i < 40; i++) begin
      RxSerial = $urandom_range(0, 1);
      @(negedge Clock);
      if (i % 8 == 7) chk("reset_outputs_zero", outs(), 0);
    end
    RxSerial = 1'b1;
    step(4);
    ResetN = 1'b1;
    step(100);
    chk("post_reset_idle_outputs", outs(), 0);

    // Single frame and consume
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    drain("single_frame_event");
    chk("single_frame_data", RxData, 8'hA5);
    chk("single_frame_valid", RxValid, 1);
    accept_byte();

    // Start glitch
    align_tick();
    RxSerial = 1'b0;
    step(12);
    RxSerial = 1'b1;
    saw = 1'b0;
    repeat (60) begin
      @(negedge Clock);
      if (Busy) saw = 1'b1;
    end
    chk("glitch_busy_seen", saw, 1);
    chk("glitch_busy_cleared", Busy, 0);
    chk("glitch_no_valid", RxValid, 0);

    // Framing error then a clean frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    drain("ferr_event");
    chk("ferr_no_valid", RxValid, 0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    drain("after_ferr_event");
    chk("after_ferr_data", RxData, 8'h55);
    accept_byte();

    // Overrun keeps the old byte
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    drain("overrun_events");
    chk("overrun_keeps_data", RxData, 8'h11);
    accept_byte();

    // Accept on the completion cycle replaces without overrun
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    drain("simul_accept_events");
    chk("simul_accept_valid", RxValid, 1);
    chk("simul_accept_data", RxData, 8'h22);
    accept_byte();

    // Reset in the middle of data bit 3 of 0xFF
    align_tick();
    RxSerial = 1'b0;
    step(BIT_CYC);
    RxSerial = 1'b1;
    step(3 * BIT_CYC + BIT_CYC / 2);
    chk("midframe_busy", Busy, 1);
    ResetN = 1'b0;
    m_valid = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      chk("midframe_reset_outputs", outs(), 0);
    end
    step(1);
    ResetN = 1'b1;
    step(6 * BIT_CYC);
    chk("midframe_recovered_idle", outs(), 0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    drain("after_reset_event");
    chk("after_reset_data", RxData, 8'h81);
    accept_byte();

    // Randomized traffic with bit-edge jitter
    for (int f = 0; f < 24; f++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok, 1'b0, 1'b1);
      if (m_valid && $urandom_range(0, 1) == 1) accept_byte();
      step($urandom_range(0, 80));
    end
    drain("random_scoreboard_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
